// File: rtl/envelope_bank.sv
// Multi-voice linear ADSR envelope generator. One shared add/clamp datapath
// visits each voice once per audio tick; note events act on any cycle.
module envelope_bank #(
  parameter int NUM_VOICES      = 8,
  parameter int AUDIO_BIT_WIDTH = 24,
  parameter int FRAC_BITS       = 8,
  parameter int SUSTAIN_WIDTH   = 7,
  parameter int TICK_DIVIDE     = 1042,
  localparam int ACC_WIDTH      = AUDIO_BIT_WIDTH + FRAC_BITS
) (
  input  logic                                  clock_50_000_000,
  input  logic                                  reset_l,
  input  logic [NUM_VOICES-1:0]                 note_on,
  input  logic [NUM_VOICES-1:0]                 note_off,
  input  logic                                  retrigger_legato,
  input  logic [ACC_WIDTH-1:0]                  attack_step,
  input  logic [ACC_WIDTH-1:0]                  decay_step,
  input  logic [ACC_WIDTH-1:0]                  release_step,
  input  logic [SUSTAIN_WIDTH-1:0]              sustain_level,
  output logic [NUM_VOICES*AUDIO_BIT_WIDTH-1:0] envelope_out,
  output logic                                  envelope_valid,
  output logic [NUM_VOICES-1:0]                 envelope_end,
  output logic [NUM_VOICES-1:0]                 voice_active
);

  localparam int COUNT_WIDTH = $clog2(TICK_DIVIDE);
  localparam int VOICE_WIDTH = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } voice_state_t;

  logic [COUNT_WIDTH-1:0]     tick_count;
  logic                       sweep_armed;
  logic                       valid_q;
  voice_state_t               state_q [NUM_VOICES];
  voice_state_t               state_d [NUM_VOICES];
  logic [ACC_WIDTH-1:0]       acc_q   [NUM_VOICES];
  logic [ACC_WIDTH-1:0]       acc_d   [NUM_VOICES];
  logic [AUDIO_BIT_WIDTH-1:0] level_q [NUM_VOICES];
  logic [AUDIO_BIT_WIDTH-1:0] level_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]      end_q;
  logic [NUM_VOICES-1:0]      end_d;

  logic                       tick_wrap;
  logic                       service_en;
  logic [VOICE_WIDTH-1:0]     service_voice;
  logic [ACC_WIDTH-1:0]       sustain_target;
  voice_state_t               cur_state;
  logic [ACC_WIDTH-1:0]       cur_acc;
  logic [ACC_WIDTH:0]         attack_sum;
  logic [ACC_WIDTH:0]         decay_diff;
  logic [ACC_WIDTH:0]         release_diff;
  voice_state_t               svc_state;
  logic [ACC_WIDTH-1:0]       svc_acc;
  logic                       svc_end;

  // The sweep only starts after a full tick wrap, so a reset mid-sweep
  // produces no partial sweep and no early envelope_valid.
  assign tick_wrap      = (tick_count == COUNT_WIDTH'(TICK_DIVIDE - 1));
  assign service_en     = sweep_armed && (tick_count < COUNT_WIDTH'(NUM_VOICES));
  assign service_voice  = tick_count[VOICE_WIDTH-1:0];
  assign sustain_target = {sustain_level, {(ACC_WIDTH - SUSTAIN_WIDTH){1'b0}}};

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      tick_count  <= '0;
      sweep_armed <= 1'b0;
      valid_q     <= 1'b0;
      end_q       <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        state_q[v] <= IDLE;
        acc_q[v]   <= '0;
        level_q[v] <= '0;
      end
    end else begin
      tick_count <= tick_wrap ? '0 : tick_count + COUNT_WIDTH'(1);
      if (tick_wrap) begin
        sweep_armed <= 1'b1;
      end
      valid_q <= sweep_armed && (tick_count == COUNT_WIDTH'(NUM_VOICES));
      end_q   <= end_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        state_q[v] <= state_d[v];
        acc_q[v]   <= acc_d[v];
        level_q[v] <= level_d[v];
      end
    end
  end

  // Shared ramp datapath: one extra bit exposes carry/borrow for saturation.
  always_comb begin
    cur_state    = state_q[service_voice];
    cur_acc      = acc_q[service_voice];
    attack_sum   = {1'b0, cur_acc} + {1'b0, attack_step};
    decay_diff   = {1'b0, cur_acc} - {1'b0, decay_step};
    release_diff = {1'b0, cur_acc} - {1'b0, release_step};
    svc_state    = cur_state;
    svc_acc      = cur_acc;
    svc_end      = 1'b0;
    case (cur_state)
      ATTACK: begin
        if (attack_step == '0 || attack_sum[ACC_WIDTH] ||
            attack_sum[ACC_WIDTH-1:0] == {ACC_WIDTH{1'b1}}) begin
          svc_acc   = {ACC_WIDTH{1'b1}};
          svc_state = DECAY;
        end else begin
          svc_acc = attack_sum[ACC_WIDTH-1:0];
        end
      end
      DECAY: begin
        if (cur_acc <= sustain_target || decay_step == '0 || decay_diff[ACC_WIDTH] ||
            decay_diff[ACC_WIDTH-1:0] <= sustain_target) begin
          svc_acc   = sustain_target;
          svc_state = SUSTAIN;
        end else begin
          svc_acc = decay_diff[ACC_WIDTH-1:0];
        end
      end
      SUSTAIN: begin
        svc_acc = sustain_target;
      end
      RELEASE: begin
        if (release_step == '0 || release_diff[ACC_WIDTH] ||
            release_diff[ACC_WIDTH-1:0] == '0) begin
          svc_acc   = '0;
          svc_state = IDLE;
          svc_end   = 1'b1;
        end else begin
          svc_acc = release_diff[ACC_WIDTH-1:0];
        end
      end
      default: begin
        svc_acc = '0;
      end
    endcase
  end

  // Note events override the ramp result; the output level still refreshes
  // on the voice's own service edge.
  always_comb begin
    end_d = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      state_d[v] = state_q[v];
      acc_d[v]   = acc_q[v];
      level_d[v] = level_q[v];
      if (service_en && service_voice == VOICE_WIDTH'(v)) begin
        state_d[v] = svc_state;
        acc_d[v]   = svc_acc;
        end_d[v]   = svc_end;
      end
      if (note_on[v]) begin
        state_d[v] = ATTACK;
        acc_d[v]   = retrigger_legato ? acc_q[v] : '0;
        end_d[v]   = 1'b0;
      end else if (note_off[v] && (state_q[v] == ATTACK || state_q[v] == DECAY ||
                                   state_q[v] == SUSTAIN)) begin
        state_d[v] = RELEASE;
        acc_d[v]   = acc_q[v];
        end_d[v]   = 1'b0;
      end
      if (service_en && service_voice == VOICE_WIDTH'(v)) begin
        level_d[v] = acc_d[v][ACC_WIDTH-1:FRAC_BITS];
      end
    end
  end

  always_comb begin
    envelope_out   = '0;
    voice_active   = '0;
    envelope_valid = valid_q;
    envelope_end   = end_q;
    for (int v = 0; v < NUM_VOICES; v++) begin
      envelope_out[v*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH] = level_q[v];
      voice_active[v] = (state_q[v] != IDLE);
    end
  end

endmodule

// File: tb/tb_envelope_bank.sv
// Bench for envelope_bank: directed ADSR scenarios followed by random note
// traffic, all compared every cycle against an integer model of the voices.
module tb_envelope_bank;

  localparam int NUM_VOICES      = 4;
  localparam int AUDIO_BIT_WIDTH = 8;
  localparam int FRAC_BITS       = 4;
  localparam int SUSTAIN_WIDTH   = 4;
  localparam int TICK_DIVIDE     = 16;
  localparam int ACC_WIDTH       = AUDIO_BIT_WIDTH + FRAC_BITS;
  localparam int MAX_LEVEL       = (1 << ACC_WIDTH) - 1;
  localparam int SUSTAIN_SCALE   = 1 << (ACC_WIDTH - SUSTAIN_WIDTH);
  localparam int OUT_SCALE       = 1 << FRAC_BITS;

  localparam int PH_IDLE    = 0;
  localparam int PH_ATTACK  = 1;
  localparam int PH_DECAY   = 2;
  localparam int PH_SUSTAIN = 3;
  localparam int PH_RELEASE = 4;

  logic                                  clock_50_000_000 = 1'b0;
  logic                                  reset_l;
  logic [NUM_VOICES-1:0]                 note_on;
  logic [NUM_VOICES-1:0]                 note_off;
  logic                                  retrigger_legato;
  logic [ACC_WIDTH-1:0]                  attack_step;
  logic [ACC_WIDTH-1:0]                  decay_step;
  logic [ACC_WIDTH-1:0]                  release_step;
  logic [SUSTAIN_WIDTH-1:0]              sustain_level;
  logic [NUM_VOICES*AUDIO_BIT_WIDTH-1:0] envelope_out;
  logic                                  envelope_valid;
  logic [NUM_VOICES-1:0]                 envelope_end;
  logic [NUM_VOICES-1:0]                 voice_active;

  envelope_bank #(
    .NUM_VOICES      (NUM_VOICES),
    .AUDIO_BIT_WIDTH (AUDIO_BIT_WIDTH),
    .FRAC_BITS       (FRAC_BITS),
    .SUSTAIN_WIDTH   (SUSTAIN_WIDTH),
    .TICK_DIVIDE     (TICK_DIVIDE)
  ) dut (
    .clock_50_000_000 (clock_50_000_000),
    .reset_l          (reset_l),
    .note_on          (note_on),
    .note_off         (note_off),
    .retrigger_legato (retrigger_legato),
    .attack_step      (attack_step),
    .decay_step       (decay_step),
    .release_step     (release_step),
    .sustain_level    (sustain_level),
    .envelope_out     (envelope_out),
    .envelope_valid   (envelope_valid),
    .envelope_end     (envelope_end),
    .voice_active     (voice_active)
  );

  always #5 clock_50_000_000 = ~clock_50_000_000;

  int assert_count = 0;
  int fail_count   = 0;

  int                    m_phase [NUM_VOICES];
  int                    m_acc   [NUM_VOICES];
  int                    m_out   [NUM_VOICES];
  logic [NUM_VOICES-1:0] m_end;
  logic                  m_valid;
  int                    edge_count;
  bit                    armed;

  task automatic model_reset();
    for (int v = 0; v < NUM_VOICES; v++) begin
      m_phase[v] = PH_IDLE;
      m_acc[v]   = 0;
      m_out[v]   = 0;
    end
    m_end      = '0;
    m_valid    = 1'b0;
    edge_count = 0;
    armed      = 1'b0;
  endtask

  // One audio-tick service of voice v, straight from the ADSR rules.
  task automatic model_service(input int v, input int target);
    case (m_phase[v])
      PH_ATTACK: begin
        if (attack_step == 0 || m_acc[v] + int'(attack_step) >= MAX_LEVEL) begin
          m_acc[v]   = MAX_LEVEL;
          m_phase[v] = PH_DECAY;
        end else begin
          m_acc[v] = m_acc[v] + int'(attack_step);
        end
      end
      PH_DECAY: begin
        if (decay_step == 0 || m_acc[v] - int'(decay_step) <= target) begin
          m_acc[v]   = target;
          m_phase[v] = PH_SUSTAIN;
        end else begin
          m_acc[v] = m_acc[v] - int'(decay_step);
        end
      end
      PH_SUSTAIN: m_acc[v] = target;
      PH_RELEASE: begin
        if (release_step == 0 || m_acc[v] - int'(release_step) <= 0) begin
          m_acc[v]   = 0;
          m_phase[v] = PH_IDLE;
          m_end[v]   = 1'b1;
        end else begin
          m_acc[v] = m_acc[v] - int'(release_step);
        end
      end
      default: m_acc[v] = 0;
    endcase
  endtask

  task automatic model_edge();
    int position;
    int target;
    bit serviced;
    position = edge_count % TICK_DIVIDE;
    target   = int'(sustain_level) * SUSTAIN_SCALE;
    m_valid  = armed && (position == NUM_VOICES);
    m_end    = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      serviced = armed && (position == v);
      if (note_on[v]) begin
        m_phase[v] = PH_ATTACK;
        if (!retrigger_legato) m_acc[v] = 0;
      end else if (note_off[v] && (m_phase[v] == PH_ATTACK || m_phase[v] == PH_DECAY ||
                                   m_phase[v] == PH_SUSTAIN)) begin
        m_phase[v] = PH_RELEASE;
      end else if (serviced) begin
        model_service(v, target);
      end
      if (serviced) m_out[v] = m_acc[v] / OUT_SCALE;
    end
    if (position == TICK_DIVIDE - 1) armed = 1'b1;
    edge_count++;
  endtask

  task automatic check_output();
    logic [NUM_VOICES*AUDIO_BIT_WIDTH-1:0] exp_out;
    logic [NUM_VOICES-1:0]                 exp_active;
    for (int v = 0; v < NUM_VOICES; v++) begin
      exp_out[v*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH] = AUDIO_BIT_WIDTH'(m_out[v]);
      exp_active[v] = (m_phase[v] != PH_IDLE);
    end
    assert_count++;
    assert (envelope_out === exp_out) else begin
      fail_count++;
      $error("[TB] FAIL envelope_out t=%0t observed %h expected %h", $time, envelope_out, exp_out);
    end
    assert_count++;
    assert (envelope_valid === m_valid) else begin
      fail_count++;
      $error("[TB] FAIL envelope_valid t=%0t observed %b expected %b", $time, envelope_valid, m_valid);
    end
    assert_count++;
    assert (envelope_end === m_end) else begin
      fail_count++;
      $error("[TB] FAIL envelope_end t=%0t observed %b expected %b", $time, envelope_end, m_end);
    end
    assert_count++;
    assert (voice_active === exp_active) else begin
      fail_count++;
      $error("[TB] FAIL voice_active t=%0t observed %b expected %b", $time, voice_active, exp_active);
    end
  endtask

  task automatic check_value(input string tag, input int observed, input int expected);
    assert_count++;
    assert (observed == expected) else begin
      fail_count++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step_cycle();
    @(posedge clock_50_000_000);
    model_edge();
    #1;
    check_output();
  endtask

  task automatic apply_stimulus(input logic [NUM_VOICES-1:0] on_mask,
                                input logic [NUM_VOICES-1:0] off_mask);
    note_on  = on_mask;
    note_off = off_mask;
    step_cycle();
    note_on  = '0;
    note_off = '0;
  endtask

  task automatic run_to_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * TICK_DIVIDE && !seen; i++) begin
      step_cycle();
      if (envelope_valid === 1'b1) seen = 1'b1;
    end
    assert_count++;
    assert (seen) else begin
      fail_count++;
      $error("[TB] FAIL sweep_timeout observed no envelope_valid expected one within %0d cycles",
             3 * TICK_DIVIDE);
    end
  endtask

  function automatic int voice_level(input int v);
    return int'(envelope_out[v*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH]);
  endfunction

  initial begin
    int ramp_expect [4];
    logic [NUM_VOICES-1:0] on_mask;
    logic [NUM_VOICES-1:0] off_mask;
    bit found;

    reset_l          = 1'b1;
    note_on          = '0;
    note_off         = '0;
    retrigger_legato = 1'b0;
    attack_step      = '0;
    decay_step       = '0;
    release_step     = '0;
    sustain_level    = '0;
    model_reset();
    #2 reset_l = 1'b0;
    #1 check_output();
    repeat (2) @(posedge clock_50_000_000);
    @(negedge clock_50_000_000);
    reset_l = 1'b1;

    // Attack ramp, decay to sustain, hold.
    $display("[TB] attack / decay / sustain on voice 0");
    attack_step   = 12'd1024;
    decay_step    = 12'd512;
    sustain_level = 4'd8;
    apply_stimulus(4'b0001, 4'b0000);
    ramp_expect = '{64, 128, 192, 255};
    for (int i = 0; i < 4; i++) begin
      run_to_valid();
      check_value("attack_ramp", voice_level(0), ramp_expect[i]);
    end
    ramp_expect = '{223, 191, 159, 128};
    for (int i = 0; i < 4; i++) begin
      run_to_valid();
      check_value("decay_ramp", voice_level(0), ramp_expect[i]);
    end
    run_to_valid();
    check_value("sustain_hold", voice_level(0), 128);

    $display("[TB] release on voice 0");
    release_step = 12'd1024;
    apply_stimulus(4'b0000, 4'b0001);
    run_to_valid();
    check_value("release_ramp", voice_level(0), 64);
    run_to_valid();
    check_value("release_floor", voice_level(0), 0);
    check_value("release_inactive", int'(voice_active[0]), 0);

    $display("[TB] retrigger on voice 1");
    apply_stimulus(4'b0010, 4'b0000);
    run_to_valid();
    run_to_valid();
    check_value("retrig_setup", voice_level(1), 128);
    apply_stimulus(4'b0010, 4'b0000);
    run_to_valid();
    check_value("retrig_restart", voice_level(1), 64);
    run_to_valid();
    retrigger_legato = 1'b1;
    apply_stimulus(4'b0010, 4'b0000);
    retrigger_legato = 1'b0;
    run_to_valid();
    check_value("retrig_legato", voice_level(1), 192);

    $display("[TB] simultaneous events and idle note_off");
    attack_step = 12'd0;
    decay_step  = 12'd0;
    apply_stimulus(4'b0100, 4'b0000);
    run_to_valid();
    check_value("zero_attack", voice_level(2), 255);
    run_to_valid();
    check_value("zero_decay", voice_level(2), 128);
    apply_stimulus(4'b0100, 4'b0100);
    check_value("on_wins_active", int'(voice_active[2]), 1);
    run_to_valid();
    check_value("on_wins_level", voice_level(2), 255);
    apply_stimulus(4'b0000, 4'b1000);
    check_value("idle_off_active", int'(voice_active[3]), 0);
    repeat (4) step_cycle();

    $display("[TB] reset in the middle of a sweep");
    attack_step = 12'd200;
    apply_stimulus(4'b1111, 4'b0000);
    found = 1'b0;
    for (int i = 0; i < 2 * TICK_DIVIDE && !found; i++) begin
      step_cycle();
      if (armed && (edge_count % TICK_DIVIDE) == 2) found = 1'b1;
    end
    @(negedge clock_50_000_000);
    reset_l = 1'b0;
    model_reset();
    #1;
    check_value("reset_out", int'(envelope_out != '0), 0);
    check_value("reset_active", int'(voice_active), 0);
    check_value("reset_valid", int'(envelope_valid), 0);
    check_output();
    repeat (2) @(posedge clock_50_000_000);
    @(negedge clock_50_000_000);
    reset_l = 1'b1;
    repeat (TICK_DIVIDE) step_cycle();
    run_to_valid();

    $display("[TB] random note traffic");
    for (int c = 0; c < 1200; c++) begin
      if (c % 40 == 0) begin
        attack_step      = ($urandom_range(0, 5) == 0) ? 12'd0 : 12'($urandom_range(1, 1500));
        decay_step       = ($urandom_range(0, 5) == 0) ? 12'd0 : 12'($urandom_range(1, 1500));
        release_step     = ($urandom_range(0, 5) == 0) ? 12'd0 : 12'($urandom_range(1, 1500));
        sustain_level    = 4'($urandom_range(0, 15));
        retrigger_legato = 1'($urandom_range(0, 1));
      end
      on_mask  = '0;
      off_mask = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if ($urandom_range(0, 63) == 0) on_mask[v] = 1'b1;
        if ($urandom_range(0, 47) == 0) off_mask[v] = 1'b1;
      end
      apply_stimulus(on_mask, off_mask);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
